// File: rtl/quadric_root_collector.sv
// Root-pair FIFO between the quadric intersector and downstream shading; optional drop statistics via QUADRIC_COLLECTOR_STATS_EN.
// Latency: a pushed pair is visible at the outputs one cycle after the push edge; pops advance the head on the next cycle.
// Backpressure: stall is an almost-full advisory (count >= DEPTH-1); pushes into a full FIFO without a same-cycle pop are dropped and flagged.
module quadric_root_collector #(
    parameter int DEPTH = 4,
    parameter int W     = 65
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_ready,
    input  logic [W-1:0]                 in_left_root,
    input  logic [W-1:0]                 in_right_root,
    input  logic                         flush,
    output logic                         stall,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_left_root,
    output logic [W-1:0]                 out_right_root,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic [15:0]                  drop_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

    typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic [2*W-1:0]    mem_q [DEPTH];
    logic [2*W-1:0]    head;
    logic              is_full;
    logic              push_acc;
    logic              pop;
    logic              drop;

    // Push/pop qualification; flush overrides both and a flushed push is not a drop
    always_comb begin
        pop      = out_valid && out_ready && !flush;
        push_acc = in_ready && !flush && (!is_full || pop);
        drop     = in_ready && !flush && is_full && !pop;
    end

    // Next-state for counters, pointers and the sticky overflow flag
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q || drop;
        if (flush) begin
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_acc && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push_acc) count_d = count_q - CW'(1);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // FSM next state simply tracks the post-update occupancy
    always_comb begin
        state_d = ACTIVE;
        if (count_d == '0)          state_d = EMPTY;
        else if (count_d == FULL_CNT) state_d = FULL;
    end

    // FSM outputs; roots are forced to zero while empty so reset shows all-zero outputs
    always_comb begin
        out_valid      = (state_q != EMPTY);
        is_full        = (state_q == FULL);
        stall          = (count_q >= STALL_CNT);
        head           = mem_q[rd_ptr_q];
        out_left_root  = out_valid ? head[2*W-1:W] : '0;
        out_right_root = out_valid ? head[W-1:0]   : '0;
        count          = count_q;
        overflow       = overflow_q;
    end

    // Data storage needs no reset: entries are only observable while valid
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= {in_left_root, in_right_root};
    end

`ifdef QUADRIC_COLLECTOR_STATS_EN
    logic [15:0] drop_q, drop_d;

    // Saturating drop counter, cleared by flush
    always_comb begin
        drop_d = drop_q;
        if (flush)                          drop_d = '0;
        else if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end

    // Drop counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) drop_q <= '0;
        else        drop_q <= drop_d;
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 16'h0000;
`endif

endmodule
